lsu_ctrl: RTL

Load/store unit controller: the initiator side of the data-memory bus. It accepts one load or store request at a time from the execute stage. It converts the byte address, size and signedness into word-aligned memory accesses with byte enables and lane-shifted store data. Misaligned accesses are split into two word accesses. Load data is realigned and sign- or zero-extended before being returned with a single-cycle response pulse.

---
 rtl/lsu_ctrl.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl - load/store unit controller, initiator side of the data-memory bus.
//
// Takes one load or store at a time from the execute stage and turns it into
// one or two word-aligned bus accesses with byte enables. A misaligned access
// that crosses a word boundary is split into two consecutive word accesses.
// Load data is realigned, sign/zero-extended and returned with a one-cycle
// response pulse. Illegal requests complete immediately with resp_err.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   request handshake; ready only while idle
//   req_load/req_store    request kind (exactly one must be set)
//   req_funct3            RISC-V funct3 size/signedness encoding
//   req_addr, req_wdata   byte address, right-justified store data
//   mem_read/mem_write    bus strobes
//   mem_addr/mem_wdata    word-aligned address, lane-aligned store data
//   mem_byteen            byte-lane enables
//   mem_rdata             read data, valid in the same cycle as mem_read
//   resp_valid            one-cycle completion pulse
//   resp_rdata, resp_err  extended load result, illegal-request flag
module lsu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_load,
    input  logic             req_store,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             mem_read,
    output logic             mem_write,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_byteen,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC0 = 2'd1,
        S_ACC1 = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // Lanes covered by an access of the given size, starting at lane 0.
    function automatic logic [3:0] size_lanes(input logic [1:0] size);
        logic [3:0] lanes;
        case (size)
            2'b00:   lanes = 4'b0001;
            2'b01:   lanes = 4'b0011;
            default: lanes = 4'b1111;
        endcase
        return lanes;
    endfunction

    // Expand a 4-bit lane enable into a 32-bit bit mask.
    function automatic logic [31:0] lane_bits(input logic [3:0] lanes);
        logic [31:0] bits;
        for (int i = 0; i < 4; i++) begin
            bits[8*i +: 8] = {8{lanes[i]}};
        end
        return bits;
    endfunction

    // 8-lane mask over two adjacent words; the upper half selects the second word.
    function automatic logic [7:0] access_mask(input logic [1:0] size, input logic [1:0] off);
        return {4'b0000, size_lanes(size)} << off;
    endfunction

    // Store data trimmed to the access size and shifted into its lanes.
    function automatic logic [63:0] store_lanes(input logic [31:0] wdata, input logic [1:0] size,
                                                input logic [1:0] off);
        return {32'h0000_0000, wdata & lane_bits(size_lanes(size))} << {off, 3'b000};
    endfunction

    function automatic logic legal_req(input logic ld, input logic st, input logic [2:0] f3);
        logic ok;
        if (ld == st) begin
            ok = 1'b0;
        end else if (ld) begin
            ok = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
        end else begin
            ok = (f3[2] == 1'b0) && (f3[1:0] != 2'b11);
        end
        return ok;
    endfunction

    // Shift the two-word buffer down to the requested byte and extend.
    function automatic logic [31:0] load_extend(input logic [63:0] rbuf, input logic [2:0] f3,
                                                input logic [1:0] off);
        logic [31:0] sh;
        logic [31:0] res;
        sh = 32'(rbuf >> {off, 3'b000});
        case (f3[1:0])
            2'b00:   res = f3[2] ? {24'h00_0000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'b01:   res = f3[2] ? {16'h0000, sh[15:0]}   : {{16{sh[15]}}, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    state_t           state_q, state_d;
    logic             load_q;
    logic [2:0]       funct3_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [63:0]      rbuf_q, rbuf_d;

    logic             mem_read_q,   mem_read_d;
    logic             mem_write_q,  mem_write_d;
    logic [WIDTH-1:0] mem_addr_q,   mem_addr_d;
    logic [WIDTH-1:0] mem_wdata_q,  mem_wdata_d;
    logic [3:0]       mem_byteen_q, mem_byteen_d;
    logic             resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic             resp_err_q,   resp_err_d;

    logic             accept_s;
    logic             legal_s;
    logic             cur_load_s;
    logic [2:0]       cur_funct3_s;
    logic [WIDTH-1:0] cur_addr_s;
    logic [WIDTH-1:0] cur_wdata_s;
    logic [7:0]       mask_s;
    logic [63:0]      wide_wdata_s;
    logic             split_s;

    assign accept_s = req_valid && (state_q == S_IDLE);
    assign legal_s  = legal_req(req_load, req_store, req_funct3);

    // Outputs are registered from the next state, so on the accept edge the
    // incoming request fields are used directly; afterwards the latched copy.
    assign cur_load_s   = accept_s ? req_load   : load_q;
    assign cur_funct3_s = accept_s ? req_funct3 : funct3_q;
    assign cur_addr_s   = accept_s ? req_addr   : addr_q;
    assign cur_wdata_s  = accept_s ? req_wdata  : wdata_q;

    assign mask_s       = access_mask(cur_funct3_s[1:0], cur_addr_s[1:0]);
    assign wide_wdata_s = store_lanes(cur_wdata_s, cur_funct3_s[1:0], cur_addr_s[1:0]);
    assign split_s      = |mask_s[7:4];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = legal_s ? S_ACC0 : S_RESP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACC0:  state_d = split_s ? S_ACC1 : S_RESP;
            S_ACC1:  state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and the load buffer.
    always_comb begin
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        mem_byteen_d = 4'b0000;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        rbuf_d       = rbuf_q;

        // Capture only the lanes enabled on the bus this cycle.
        case (state_q)
            S_ACC0: begin
                if (load_q) begin
                    rbuf_d = {32'h0000_0000, mem_rdata & lane_bits(mem_byteen_q)};
                end else begin
                    rbuf_d = rbuf_q;
                end
            end
            S_ACC1: begin
                if (load_q) begin
                    rbuf_d = {mem_rdata & lane_bits(mem_byteen_q), rbuf_q[31:0]};
                end else begin
                    rbuf_d = rbuf_q;
                end
            end
            default: rbuf_d = rbuf_q;
        endcase

        case (state_d)
            S_ACC0: begin
                mem_read_d   = cur_load_s;
                mem_write_d  = !cur_load_s;
                mem_addr_d   = {cur_addr_s[WIDTH-1:2], 2'b00};
                mem_byteen_d = mask_s[3:0];
                mem_wdata_d  = cur_load_s ? 32'h0000_0000 : wide_wdata_s[31:0];
            end
            S_ACC1: begin
                mem_read_d   = cur_load_s;
                mem_write_d  = !cur_load_s;
                // Natural 32-bit overflow gives the 0xFFFFFFFC -> 0 wrap.
                mem_addr_d   = {cur_addr_s[WIDTH-1:2], 2'b00} + 32'd4;
                mem_byteen_d = mask_s[7:4];
                mem_wdata_d  = cur_load_s ? 32'h0000_0000 : wide_wdata_s[63:32];
            end
            S_RESP: begin
                resp_valid_d = 1'b1;
                // RESP straight from IDLE only happens for an illegal request.
                resp_err_d   = (state_q == S_IDLE);
                if ((state_q != S_IDLE) && cur_load_s) begin
                    resp_rdata_d = load_extend(rbuf_d, cur_funct3_s, cur_addr_s[1:0]);
                end else begin
                    resp_rdata_d = '0;
                end
            end
            default: begin
                mem_read_d = 1'b0;
            end
        endcase
    end

    // Request fields latched on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_q   <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if (accept_s) begin
            load_q   <= req_load;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
        end
    end

    // Output registers and load buffer; reset drops strobes asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_byteen_q <= 4'b0000;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            rbuf_q       <= 64'h0;
        end else begin
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_byteen_q <= mem_byteen_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            rbuf_q       <= rbuf_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_byteen = mem_byteen_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule
